// File: rtl/nn_output_argmax_reader.sv
// nn_output_argmax_reader
//
// Reduces the output-layer activation vector of the feed-forward network to
// a classified digit. On an accepted start, all activations are captured
// into a snapshot. They are then scanned one class per clock through a
// single signed comparator. The winner is reported with a one-cycle done
// pulse.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        classification request, sampled only while ready = 1
//   act_flat     activations, class k at bits [k*DATA_W +: DATA_W]
//   ready        high while idle
//   done         one-cycle pulse; result outputs valid from this cycle on
//   class_idx    index of the maximum activation (lowest index on a tie)
//   class_score  value of the maximum activation
//   tie          another class holds the same maximum value
module nn_output_argmax_reader #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NUM_CLASSES*DATA_W-1:0] act_flat,
    output logic                          ready,
    output logic                          done,
    output logic [IDX_W-1:0]              class_idx,
    output logic signed [DATA_W-1:0]      class_score,
    output logic                          tie
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    logic [1:0]               state;
    logic [IDX_W-1:0]         ptr;
    logic signed [DATA_W-1:0] snap [NUM_CLASSES];
    logic signed [DATA_W-1:0] best_val;
    logic [IDX_W-1:0]         best_idx;
    logic                     best_tie;

    logic signed [DATA_W-1:0] cur_val;
    logic signed [DATA_W-1:0] nxt_val;
    logic [IDX_W-1:0]         nxt_idx;
    logic                     nxt_tie;

    assign ready = (state == ST_IDLE);

    // The first SCAN cycle (ptr = 0) seeds the running best from snap[0].
    // Every class therefore owns exactly one scan cycle, and done lands
    // NUM_CLASSES cycles after the start edge. Later cycles use one signed
    // compare. Equality only raises the tie flag, so the lowest index keeps
    // the win. A strictly larger value clears the flag.
    always_comb begin
        cur_val = snap[ptr];
        nxt_val = best_val;
        nxt_idx = best_idx;
        nxt_tie = best_tie;
        if (ptr == '0) begin
            nxt_val = cur_val;
            nxt_idx = '0;
            nxt_tie = 1'b0;
        end else if (cur_val > best_val) begin
            nxt_val = cur_val;
            nxt_idx = ptr;
            nxt_tie = 1'b0;
        end else if (cur_val == best_val) begin
            nxt_tie = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            best_val    <= '0;
            best_idx    <= '0;
            best_tie    <= 1'b0;
            done        <= 1'b0;
            class_idx   <= '0;
            class_score <= '0;
            tie         <= 1'b0;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                snap[k] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Snapshot isolates the result from later act_flat changes.
                        for (int k = 0; k < NUM_CLASSES; k++) begin
                            snap[k] <= act_flat[k*DATA_W +: DATA_W];
                        end
                        ptr   <= '0;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    best_val <= nxt_val;
                    best_idx <= nxt_idx;
                    best_tie <= nxt_tie;
                    if (ptr == LAST_IDX) begin
                        // The result is taken from the final compare directly,
                        // so it is already valid in the done cycle.
                        class_idx   <= nxt_idx;
                        class_score <= nxt_val;
                        tie         <= nxt_tie;
                        done        <= 1'b1;
                        ptr         <= '0;
                        state       <= ST_DONE;
                    end else begin
                        ptr <= ptr + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_output_argmax_reader.sv
module tb_nn_output_argmax_reader;

    localparam int N  = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [N*DW-1:0] act_flat = '0;
    logic ready, done, tie;
    logic [3:0] class_idx;
    logic signed [DW-1:0] class_score;

    logic start2 = 1'b0;
    logic [2*DW-1:0] act2 = '0;
    logic ready2, done2, tie2;
    logic [0:0] class_idx2;
    logic signed [DW-1:0] class_score2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    nn_output_argmax_reader #(.NUM_CLASSES(N), .DATA_W(DW), .IDX_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .act_flat(act_flat),
        .ready(ready), .done(done), .class_idx(class_idx),
        .class_score(class_score), .tie(tie));

    nn_output_argmax_reader #(.NUM_CLASSES(2), .DATA_W(DW), .IDX_W(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .act_flat(act2),
        .ready(ready2), .done(done2), .class_idx(class_idx2),
        .class_score(class_score2), .tie(tie2));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Reference classification: largest value, first occurrence, and a tie
    // whenever that value occurs more than once.
    function automatic void argmax(input logic signed [DW-1:0] v [N],
                                   output int idx, output logic signed [DW-1:0] mx,
                                   output bit t);
        int cnt;
        mx = v[0];
        idx = 0;
        for (int i = 1; i < N; i++) begin
            if (v[i] > mx) begin
                mx = v[i];
                idx = i;
            end
        end
        cnt = 0;
        for (int i = 0; i < N; i++) if (v[i] == mx) cnt++;
        t = (cnt > 1);
    endfunction

    // Transaction-level model: an accepted start makes the block busy for
    // N+1 cycles, the last of which is the done cycle carrying the result.
    logic signed [DW-1:0] mv [N];
    int                   m_busy = 0;
    logic                 m_done = 1'b0;
    int                   m_idx = 0;
    logic signed [DW-1:0] m_score = '0;
    bit                   m_tie = 1'b0;
    int                   p_idx = 0;
    logic signed [DW-1:0] p_score = '0;
    bit                   p_tie = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 1'b0; m_idx = 0; m_score = '0; m_tie = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_busy == 0) begin
                if (start) begin
                    for (int i = 0; i < N; i++) mv[i] = act_flat[i*DW +: DW];
                    argmax(mv, p_idx, p_score, p_tie);
                    m_busy = N + 1;
                end
            end else begin
                m_busy--;
                if (m_busy == 1) begin
                    m_done = 1'b1; m_idx = p_idx; m_score = p_score; m_tie = p_tie;
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        chk("ready", 64'(ready), 64'(m_busy == 0));
        chk("done", 64'(done), 64'(m_done));
        chk("class_idx", 64'(class_idx), 64'(m_idx));
        chk("class_score", 64'(class_score), 64'(m_score));
        chk("tie", 64'(tie), 64'(m_tie));
    end

    logic signed [DW-1:0] vec [N];

    task automatic load();
        for (int i = 0; i < N; i++) act_flat[i*DW +: DW] = vec[i];
    endtask

    // Pulse start, then watch until ready returns: latency of done and the
    // number of sampled cycles with ready low.
    task automatic do_op(output int lat, output int rdy_low);
        lat = -1;
        rdy_low = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!ready) rdy_low++;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) lat = k;
            if (ready) break;
            rdy_low++;
        end
        if (lat < 0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int lat, rl, ndone, didx, ri;
        int dcyc [$];
        logic signed [DW-1:0] rs;
        bit rt;

        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_idx", 64'(class_idx), 64'd0);
        chk("rst_score", 64'(class_score), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Distinct values
        vec = '{5, 1, 9, 3, 0, 2, 7, 4, 8, 6};
        argmax(vec, ri, rs, rt);
        chk("model_idx", 64'(ri), 64'd2);
        chk("model_tie", 64'(rt), 64'd0);
        load();
        do_op(lat, rl);
        chk("distinct_lat", 64'(lat), 64'd10);
        chk("distinct_ready_low", 64'(rl), 64'd11);
        chk("distinct_idx", 64'(class_idx), 64'd2);
        chk("distinct_score", 64'(class_score), 64'd9);
        chk("distinct_tie", 64'(tie), 64'd0);

        // Negative values, most negative in class 0
        for (int i = 0; i < N; i++) vec[i] = -32'sd16;
        vec[7] = -32'sd1;
        vec[0] = 32'sh8000_0000;
        load();
        do_op(lat, rl);
        chk("neg_idx", 64'(class_idx), 64'd7);
        chk("neg_score", 64'(class_score), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("neg_tie", 64'(tie), 64'd0);

        // Ties
        for (int i = 0; i < N; i++) vec[i] = 32'sd50;
        vec[3] = 32'sd100;
        vec[8] = 32'sd100;
        load();
        do_op(lat, rl);
        chk("tie_idx", 64'(class_idx), 64'd3);
        chk("tie_flag", 64'(tie), 64'd1);
        vec[9] = 32'sd101;
        load();
        do_op(lat, rl);
        chk("tie_clear_idx", 64'(class_idx), 64'd9);
        chk("tie_clear_flag", 64'(tie), 64'd0);

        // Snapshot isolation and start while busy
        vec = '{5, 1, 9, 3, 0, 2, 7, 4, 8, 6};
        load();
        ndone = 0;
        didx = -1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 25; k++) begin
            if (k >= 2 && k <= 5) begin
                for (int i = 0; i < N; i++) act_flat[i*DW +: DW] = 32'(1000 + i);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                didx = int'(class_idx);
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("snap_done_count", 64'(ndone), 64'd1);
        chk("snap_idx", 64'(didx), 64'd2);

        // Start held high: back-to-back operations
        load();
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) dcyc.push_back(k);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        chk("cont_done_count", 64'(dcyc.size()), 64'd3);
        if (dcyc.size() == 3) begin
            chk("cont_first", 64'(dcyc[0]), 64'd10);
            chk("cont_period", 64'(dcyc[1] - dcyc[0]), 64'd12);
        end

        // Reset in the middle of a scan
        for (int i = 0; i < N; i++) vec[i] = 32'sd50;
        vec[4] = 32'sd77;
        load();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_ready", 64'(ready), 64'd1);
        chk("mid_rst_score", 64'(class_score), 64'd0);
        ndone = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        chk("mid_rst_no_done", 64'(ndone), 64'd0);
        chk("mid_rst_idx", 64'(class_idx), 64'd0);
        do_op(lat, rl);
        chk("after_rst_lat", 64'(lat), 64'd10);
        chk("after_rst_idx", 64'(class_idx), 64'd4);
        chk("after_rst_score", 64'(class_score), 64'd77);

        // Two-class build
        act2 = {-32'sd3, -32'sd3};
        lat = -1;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int k = 1; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (done2 && lat < 0) begin
                lat = k;
                chk("n2_idx", 64'(class_idx2), 64'd0);
                chk("n2_tie", 64'(tie2), 64'd1);
                chk("n2_score", 64'(class_score2), 64'hFFFF_FFFF_FFFF_FFFD);
            end
        end
        chk("n2_lat", 64'(lat), 64'd2);
        chk("n2_ready", 64'(ready2), 64'd1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
